// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
// NW write ports and NR read ports operate every cycle with no stalls.
// Reads are registered and write-first: a read that hits an address being
// written at the same edge returns the new data. When several enabled write
// ports target one address, the highest-index port wins and the sticky
// wr_conflict flag is raised until reset.
// Optional feature macro: REGFILE_ZERO_REG_EN -- entry 0 is hardwired to zero,
// writes to address 0 are dropped and never count as a collision.
// The whole array is cleared by the asynchronous reset, so it is built from
// flops rather than block RAM.
module regfile_mp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NR     = 4,
  parameter int NW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR-1:0]        re,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rvalid,
  output logic                 wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Effective write enables: with the zero register, address 0 writes are
  // removed here so they touch neither the array, the bypass nor the flag.
  logic [NW-1:0] wen;

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_wen
`ifdef REGFILE_ZERO_REG_EN
      assign wen[gi] = we[gi] && (waddr[gi*ADDR_W +: ADDR_W] != '0);
`else
      assign wen[gi] = we[gi];
`endif
    end
  endgenerate

  // Detect any pair of enabled write ports sharing an address this cycle
  logic collide;
  always_comb begin
    collide = 1'b0;
    for (int a = 0; a < NW; a++) begin
      for (int b = a + 1; b < NW; b++) begin
        if (wen[a] && wen[b] &&
            (waddr[a*ADDR_W +: ADDR_W] == waddr[b*ADDR_W +: ADDR_W])) begin
          collide = 1'b1;
        end
      end
    end
  end

  // Array update; ports are applied in ascending order so the last
  // (highest-index) assignment to a shared address is the one that sticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wen[i]) begin
          mem[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Sticky collision flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_conflict <= 1'b0;
    end else if (collide) begin
      wr_conflict <= 1'b1;
    end
  end

  // Per read port: write-first data selection and the output registers
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_next;
      logic [DATA_W-1:0] rdata_reg;
      logic              rvalid_reg;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      // Array data, overridden by any matching enabled write (last port wins)
      always_comb begin
        rd_next = mem[ra];
        for (int i = 0; i < NW; i++) begin
          if (wen[i] && (waddr[i*ADDR_W +: ADDR_W] == ra)) begin
            rd_next = wdata[i*DATA_W +: DATA_W];
          end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (ra == '0) begin
          rd_next = '0;
        end
`endif
      end

      // Capture on re, otherwise hold; rvalid mirrors the sampled re
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= re[gi];
          if (re[gi]) begin
            rdata_reg <= rd_next;
          end
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rdata_reg;
      assign rvalid[gi]                 = rvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven bench for regfile_mp (default 64x32, 4R/2W).
// Each vector carries its stimulus and hand-derived expected outputs; the
// expectation is queued when the vector is driven and compared after the
// capturing edge. The asynchronous reset case is a hand-written sequence
// between the two halves of the table.
module tb_regfile_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NR     = 4;
  localparam int NW     = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NW-1:0]        we;
  logic [NW*ADDR_W-1:0] waddr;
  logic [NW*DATA_W-1:0] wdata;
  logic [NR-1:0]        re;
  logic [NR*ADDR_W-1:0] raddr;
  logic [NR*DATA_W-1:0] rdata;
  logic [NR-1:0]        rvalid;
  logic                 wr_conflict;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   we;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [3:0]   re;
    logic [19:0]  raddr;
    logic [255:0] erd;
    logic [3:0]   erv;
    logic         ec;
  } vec_t;

  typedef struct {
    logic [255:0] rd;
    logic [3:0]   rv;
    logic         c;
  } exp_t;

  localparam int NV = 15;
  localparam int N1 = 12;

  vec_t vt [NV];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [1:0] w, input logic [4:0] wa0, input logic [63:0] wd0,
    input logic [4:0] wa1, input logic [63:0] wd1, input logic [3:0] r,
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
    input logic [4:0] ra3, input logic [63:0] e0, input logic [63:0] e1,
    input logic [63:0] e2, input logic [63:0] e3, input logic [3:0] erv,
    input logic ec);
    vec_t v;
    v.we    = w;
    v.waddr = {wa1, wa0};
    v.wdata = {wd1, wd0};
    v.re    = r;
    v.raddr = {ra3, ra2, ra1, ra0};
    v.erd   = {e3, e2, e1, e0};
    v.erv   = erv;
    v.ec    = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [255:0] erd, input logic [3:0] erv, input logic ec);
    for (int j = 0; j < NR; j++) begin
      check($sformatf("%s rdata%0d", tag, j), rdata[j*DATA_W +: DATA_W], erd[j*DATA_W +: DATA_W]);
    end
    check({tag, " rvalid"}, {60'd0, rvalid}, {60'd0, erv});
    check({tag, " wr_conflict"}, {63'd0, wr_conflict}, {63'd0, ec});
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
  endtask

  // Drive one vector (inputs change at the falling edge), queue its
  // expectation, then compare after the capturing rising edge.
  task automatic apply(input int idx);
    exp_t e;
    we = vt[idx].we; waddr = vt[idx].waddr; wdata = vt[idx].wdata;
    re = vt[idx].re; raddr = vt[idx].raddr;
    e.rd = vt[idx].erd; e.rv = vt[idx].erv; e.c = vt[idx].ec;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_outputs($sformatf("vec%0d", idx), e.rd, e.rv, e.c);
    $display("vec%0d we=%b re=%b rvalid=%b wr_conflict=%b", idx, we, re, rvalid, wr_conflict);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] fz;
    logic        cz;
    fz = ZERO ? 64'h0 : 64'hFFFF;
    cz = ZERO ? 1'b0 : 1'b1;

    //        we     wa0   wd0                      wa1   wd1      re       ra0 ra1 ra2 ra3   e0                      e1     e2       e3       erv      ec
    vt[0]  = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b1111, 0, 1, 2, 3, 64'h0,                  64'h0, 64'h0,    64'h0,    4'b1111, 1'b0);
    vt[1]  = mk(2'b11, 5'd4, 64'hDEAD_BEEF_0123_4567, 5'd5, 64'h1,  4'b0000, 0, 0, 0, 0, 64'h0,                  64'h0, 64'h0,    64'h0,    4'b0000, 1'b0);
    vt[2]  = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b0011, 4, 5, 0, 0, 64'hDEAD_BEEF_0123_4567, 64'h1, 64'h0,    64'h0,    4'b0011, 1'b0);
    vt[3]  = mk(2'b01, 5'd9, 64'h99,                5'd9, 64'h77,   4'b0001, 9, 0, 0, 0, 64'h99,                 64'h1, 64'h0,    64'h0,    4'b0001, 1'b0);
    vt[4]  = mk(2'b11, 5'd7, 64'hAAAA,              5'd7, 64'h5555, 4'b0100, 0, 0, 7, 0, 64'h99,                 64'h1, 64'h5555, 64'h0,    4'b0100, 1'b1);
    vt[5]  = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b1000, 0, 0, 0, 7, 64'h99,                 64'h1, 64'h5555, 64'h5555, 4'b1000, 1'b1);
    vt[6]  = mk(2'b01, 5'd5, 64'h2,                 5'd0, 64'h0,    4'b0001, 5, 5, 0, 0, 64'h2,                  64'h1, 64'h5555, 64'h5555, 4'b0001, 1'b1);
    vt[7]  = mk(2'b01, 5'd5, 64'h2,                 5'd0, 64'h0,    4'b0000, 0, 5, 0, 0, 64'h2,                  64'h1, 64'h5555, 64'h5555, 4'b0000, 1'b1);
    vt[8]  = mk(2'b01, 5'd5, 64'h2,                 5'd0, 64'h0,    4'b0000, 0, 5, 0, 0, 64'h2,                  64'h1, 64'h5555, 64'h5555, 4'b0000, 1'b1);
    vt[9]  = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b0010, 0, 5, 0, 0, 64'h2,                  64'h2, 64'h5555, 64'h5555, 4'b0010, 1'b1);
    vt[10] = mk(2'b00, 5'd4, 64'hEEEE,              5'd4, 64'hFFFF, 4'b0001, 4, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 64'h2, 64'h5555, 64'h5555, 4'b0001, 1'b1);
    vt[11] = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b0100, 0, 0, 9, 0, 64'hDEAD_BEEF_0123_4567, 64'h2, 64'h99,   64'h5555, 4'b0100, 1'b1);
    // After the mid-operation reset: zero-register behaviour and a fresh flag
    vt[12] = mk(2'b11, 5'd0, 64'hFFFF,              5'd0, 64'hFFFF, 4'b0001, 0, 0, 0, 0, fz,                     64'h0, 64'h0,    64'h0,    4'b0001, cz);
    vt[13] = mk(2'b00, 5'd0, 64'h0,                 5'd0, 64'h0,    4'b0110, 0, 0, 4, 0, fz,                     fz,    64'h0,    64'h0,    4'b0110, cz);
    vt[14] = mk(2'b10, 5'd0, 64'h0,                 5'd3, 64'h33,   4'b1000, 0, 0, 0, 3, fz,                     fz,    64'h0,    64'h33,   4'b1000, cz);

    // Power-on reset
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check_outputs("reset", 256'd0, 4'b0000, 1'b0);
    $display("reset state rvalid=%b wr_conflict=%b", rvalid, wr_conflict);
    reset = 1'b0;

    for (int i = 0; i < N1; i++) apply(i);

    // Asynchronous reset between edges while writes and reads are active
    we = 2'b11; waddr = {5'd6, 5'd4}; wdata = {64'h66, 64'h1234};
    re = 4'b1111; raddr = {5'd4, 5'd4, 5'd4, 5'd4};
    #2 reset = 1'b1;
    #1 check_outputs("async_reset", 256'd0, 4'b0000, 1'b0);
    $display("async reset mid-cycle rvalid=%b wr_conflict=%b", rvalid, wr_conflict);
    @(posedge clk);
    @(negedge clk);
    check_outputs("reset_held", 256'd0, 4'b0000, 1'b0);
    $display("edge under reset rvalid=%b wr_conflict=%b", rvalid, wr_conflict);
    idle();
    reset = 1'b0;

    for (int i = N1; i < NV; i++) apply(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
